// File: rtl/image_conv_bias_pipe.sv
// Convolution bias stage: buffers accumulator beats in an input FIFO, adds a per-channel
// bias chosen by a channel-group counter, and emits sign-extended or saturated lanes.
module image_conv_bias_pipe #(
  parameter int WIDTH_IN                = 32,
  parameter int WIDTH_BIAS              = 32,
  parameter int WIDTH_OUT               = 48,
  parameter int PICTURE_NUM             = 1,
  parameter int COMPUTE_CHANNEL_OUT_NUM = 8,
  parameter int FIFO_ADDR_BITS          = 12,
  parameter int BIAS_ADDR_BITS          = 6
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  cfg_clear,
  input  logic [7:0]                                            cfg_channel_times,
  input  logic [19:0]                                           cfg_beats_per_group,
  input  logic                                                  cfg_sat_en,
  input  logic                                                  bias_wr_en,
  input  logic [BIAS_ADDR_BITS-1:0]                             bias_wr_addr,
  input  logic [COMPUTE_CHANNEL_OUT_NUM*WIDTH_BIAS-1:0]         bias_wr_data,
  input  logic [WIDTH_IN*PICTURE_NUM*COMPUTE_CHANNEL_OUT_NUM-1:0]  s_data,
  input  logic                                                  s_valid,
  output logic                                                  s_ready,
  output logic [WIDTH_OUT*PICTURE_NUM*COMPUTE_CHANNEL_OUT_NUM-1:0] m_data,
  output logic                                                  m_valid,
  input  logic                                                  m_ready,
  output logic [FIFO_ADDR_BITS:0]                               fifo_count,
  output logic [7:0]                                            group_idx,
  output logic                                                  frame_done
);

  localparam int LANES = PICTURE_NUM * COMPUTE_CHANNEL_OUT_NUM;
  localparam int DW    = WIDTH_IN * LANES;
  localparam int BW    = COMPUTE_CHANNEL_OUT_NUM * WIDTH_BIAS;
  localparam int OW    = WIDTH_OUT * LANES;
  localparam int SUM_W = ((WIDTH_IN > WIDTH_BIAS) ? WIDTH_IN : WIDTH_BIAS) + 1;
  localparam int DEPTH = 1 << FIFO_ADDR_BITS;
  localparam logic [FIFO_ADDR_BITS:0] DEPTH_CNT = (FIFO_ADDR_BITS + 1)'(DEPTH);

  logic [DW-1:0] fifo_mem [DEPTH];
  logic [BW-1:0] bias_mem [1 << BIAS_ADDR_BITS];

  logic [FIFO_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_ADDR_BITS:0]   cnt_q, cnt_d;
  logic                      head_vld_q, head_vld_d;
  logic [DW-1:0]             head_data_q, head_data_d;
  logic [19:0]               beat_cnt_q, beat_cnt_d;
  logic [7:0]                grp_cnt_q, grp_cnt_d;
  logic                      s1_vld_q, s1_vld_d;
  logic [DW-1:0]             s1_data_q, s1_data_d;
  logic [BW-1:0]             s1_bias_q, s1_bias_d;
  logic [7:0]                s1_grp_q, s1_grp_d;
  logic                      s1_last_q, s1_last_d;
  logic                      m_valid_q, m_valid_d;
  logic [OW-1:0]             m_data_q, m_data_d;
  logic [7:0]                s2_grp_q, s2_grp_d;
  logic                      s2_last_q, s2_last_d;

  logic              push, pop, mem_rd, s1_adv, s2_adv, beat_end, grp_end;
  logic [19:0]       bpg_last;
  logic [7:0]        ct_last;
  logic [WIDTH_OUT-1:0] lane_res [LANES];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int J = k / PICTURE_NUM;
    logic signed [SUM_W-1:0] sum;
    always_comb begin
      sum = $signed({{(SUM_W-WIDTH_IN){s1_data_q[k*WIDTH_IN+WIDTH_IN-1]}},
                     s1_data_q[k*WIDTH_IN +: WIDTH_IN]})
          + $signed({{(SUM_W-WIDTH_BIAS){s1_bias_q[J*WIDTH_BIAS+WIDTH_BIAS-1]}},
                     s1_bias_q[J*WIDTH_BIAS +: WIDTH_BIAS]});
    end
    if (WIDTH_OUT >= SUM_W) begin : g_ext
      always_comb lane_res[k] = WIDTH_OUT'(sum);
    end else begin : g_sat
      localparam logic signed [SUM_W-1:0] MAX_V =
        {{(SUM_W-WIDTH_OUT+1){1'b0}}, {(WIDTH_OUT-1){1'b1}}};
      localparam logic signed [SUM_W-1:0] MIN_V = ~MAX_V;
      always_comb begin
        lane_res[k] = sum[WIDTH_OUT-1:0];
        if (cfg_sat_en) begin
          if (sum > MAX_V)      lane_res[k] = MAX_V[WIDTH_OUT-1:0];
          else if (sum < MIN_V) lane_res[k] = MIN_V[WIDTH_OUT-1:0];
        end
      end
    end
  end

  always_comb begin
    s2_adv   = !m_valid_q || m_ready;
    s1_adv   = !s1_vld_q || s2_adv;
    pop      = head_vld_q && s1_adv;
    s_ready  = (cnt_q != DEPTH_CNT);
    push     = s_valid && s_ready && !cfg_clear;
    // head register is a synchronous-read stage: refill it from the RAM whenever it empties
    mem_rd   = (!head_vld_q || pop) && (cnt_q != (FIFO_ADDR_BITS + 1)'(head_vld_q));
    ct_last  = (cfg_channel_times == '0) ? '0 : cfg_channel_times - 8'd1;
    bpg_last = (cfg_beats_per_group == '0) ? '0 : cfg_beats_per_group - 20'd1;
    beat_end = (beat_cnt_q == bpg_last);
    grp_end  = (grp_cnt_q == ct_last);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    head_vld_d  = head_vld_q;
    head_data_d = head_data_q;
    beat_cnt_d  = beat_cnt_q;
    grp_cnt_d   = grp_cnt_q;
    s1_vld_d    = s1_vld_q;
    s1_data_d   = s1_data_q;
    s1_bias_d   = s1_bias_q;
    s1_grp_d    = s1_grp_q;
    s1_last_d   = s1_last_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    s2_grp_d    = s2_grp_q;
    s2_last_d   = s2_last_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (mem_rd) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      head_data_d = fifo_mem[rd_ptr_q];
      head_vld_d  = 1'b1;
    end else if (pop) begin
      head_vld_d  = 1'b0;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (s1_adv) s1_vld_d = head_vld_q;
    if (pop) begin
      s1_data_d = head_data_q;
      s1_bias_d = bias_mem[BIAS_ADDR_BITS'(grp_cnt_q)];
      s1_grp_d  = grp_cnt_q;
      s1_last_d = beat_end && grp_end;
      if (beat_end) begin
        beat_cnt_d = '0;
        grp_cnt_d  = grp_end ? '0 : grp_cnt_q + 8'd1;
      end else begin
        beat_cnt_d = beat_cnt_q + 20'd1;
      end
    end

    if (s2_adv) m_valid_d = s1_vld_q;
    if (s2_adv && s1_vld_q) begin
      for (int unsigned k = 0; k < LANES; k++) m_data_d[k*WIDTH_OUT +: WIDTH_OUT] = lane_res[k];
      s2_grp_d  = s1_grp_q;
      s2_last_d = s1_last_q;
    end

    if (cfg_clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      head_vld_d = 1'b0;
      beat_cnt_d = '0;
      grp_cnt_d  = '0;
      s1_vld_d   = 1'b0;
      m_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (bias_wr_en) bias_mem[bias_wr_addr] <= bias_wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      head_vld_q  <= 1'b0;
      head_data_q <= '0;
      beat_cnt_q  <= '0;
      grp_cnt_q   <= '0;
      s1_vld_q    <= 1'b0;
      s1_data_q   <= '0;
      s1_bias_q   <= '0;
      s1_grp_q    <= '0;
      s1_last_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      s2_grp_q    <= '0;
      s2_last_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      head_vld_q  <= head_vld_d;
      head_data_q <= head_data_d;
      beat_cnt_q  <= beat_cnt_d;
      grp_cnt_q   <= grp_cnt_d;
      s1_vld_q    <= s1_vld_d;
      s1_data_q   <= s1_data_d;
      s1_bias_q   <= s1_bias_d;
      s1_grp_q    <= s1_grp_d;
      s1_last_q   <= s1_last_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      s2_grp_q    <= s2_grp_d;
      s2_last_q   <= s2_last_d;
    end
  end

  always_comb begin
    m_valid    = m_valid_q;
    m_data     = m_data_q;
    fifo_count = cnt_q;
    group_idx  = s2_grp_q;
    frame_done = m_valid_q && s2_last_q;
  end

endmodule

// File: tb/tb_image_conv_bias_pipe.sv
// Bench for image_conv_bias_pipe: a 16-bit-output / 4-deep-FIFO instance (scoreboarded) and a
// default-parameter instance sharing the same inputs for the sign-extension path.
module tb_image_conv_bias_pipe;

  typedef struct packed {
    logic [127:0] d;
    logic [7:0]   g;
    logic         l;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, cfg_clear, cfg_sat_en, bias_wr_en, s_valid, m_ready;
  logic [7:0]   cfg_ct;
  logic [19:0]  cfg_bpg;
  logic [5:0]   bias_wr_addr;
  logic [255:0] bias_wr_data, s_data;

  logic         a_s_ready, a_m_valid, a_frame_done;
  logic [127:0] a_m_data;
  logic [2:0]   a_fifo_count;
  logic [7:0]   a_group_idx;
  logic         b_s_ready, b_m_valid, b_frame_done;
  logic [383:0] b_m_data;
  logic [12:0]  b_fifo_count;
  logic [7:0]   b_group_idx;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  int   bias_tb [3][8];
  logic hold_q = 1'b0;
  logic [127:0] hold_d;
  logic rnd_on;

  always #5 clk = ~clk;

  image_conv_bias_pipe #(.WIDTH_OUT(16), .FIFO_ADDR_BITS(2)) dut_a (
    .clk(clk), .rst(rst), .cfg_clear(cfg_clear), .cfg_channel_times(cfg_ct),
    .cfg_beats_per_group(cfg_bpg), .cfg_sat_en(cfg_sat_en), .bias_wr_en(bias_wr_en),
    .bias_wr_addr(bias_wr_addr), .bias_wr_data(bias_wr_data), .s_data(s_data),
    .s_valid(s_valid), .s_ready(a_s_ready), .m_data(a_m_data), .m_valid(a_m_valid),
    .m_ready(m_ready), .fifo_count(a_fifo_count), .group_idx(a_group_idx),
    .frame_done(a_frame_done));

  image_conv_bias_pipe dut_b (
    .clk(clk), .rst(rst), .cfg_clear(cfg_clear), .cfg_channel_times(cfg_ct),
    .cfg_beats_per_group(cfg_bpg), .cfg_sat_en(cfg_sat_en), .bias_wr_en(bias_wr_en),
    .bias_wr_addr(bias_wr_addr), .bias_wr_data(bias_wr_data), .s_data(s_data),
    .s_valid(s_valid), .s_ready(b_s_ready), .m_data(b_m_data), .m_valid(b_m_valid),
    .m_ready(m_ready), .fifo_count(b_fifo_count), .group_idx(b_group_idx),
    .frame_done(b_frame_done));

  task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] v32(input int base, input int stp);
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[j*32 +: 32] = 32'(base + j*stp);
    return r;
  endfunction

  function automatic logic [127:0] pk16(input int base, input int stp);
    logic [127:0] r;
    for (int j = 0; j < 8; j++) r[j*16 +: 16] = 16'(base + j*stp);
    return r;
  endfunction

  function automatic logic [383:0] pk48(input int base, input int stp);
    logic [383:0] r;
    for (int j = 0; j < 8; j++) r[j*48 +: 48] = 48'(longint'(base + j*stp));
    return r;
  endfunction

  function automatic exp_t mk(input logic [127:0] d, input int g, input logic l);
    exp_t e;
    e.d = d; e.g = 8'(g); e.l = l;
    return e;
  endfunction

  // saturating 16-bit reference used for the randomised traffic
  function automatic exp_t model(input logic [255:0] din, input int g, input logic l);
    exp_t  e;
    longint s;
    for (int j = 0; j < 8; j++) begin
      s = longint'($signed(din[j*32 +: 32])) + longint'(bias_tb[g][j]);
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      e.d[j*16 +: 16] = 16'(s);
    end
    e.g = 8'(g); e.l = l;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bias_load(input int addr, input logic [255:0] d);
    bias_wr_en = 1'b1; bias_wr_addr = 6'(addr); bias_wr_data = d;
    step();
    bias_wr_en = 1'b0;
  endtask

  task automatic set_cfg(input int ct, input int bpg, input logic sat);
    cfg_ct = 8'(ct); cfg_bpg = 20'(bpg); cfg_sat_en = sat;
    cfg_clear = 1'b1;
    step();
    cfg_clear = 1'b0;
  endtask

  task automatic push(input logic [255:0] d, input exp_t e);
    logic rdy;
    int   n = 0;
    s_valid = 1'b1; s_data = d;
    do begin
      rdy = a_s_ready;
      step();
      n++;
    end while (!rdy && n < 500);
    s_valid = 1'b0;
    if (rdy) exp_q.push_back(e);
    else check("push_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      step();
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    step(); step();
  endtask

  task automatic b_expect(input logic [383:0] e);
    logic seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = b_m_valid;
    end
    check("b_valid", b_m_valid, 1);
    check("b_data", b_m_data, e);
    check("b_done", b_frame_done, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_m_valid && m_ready) begin
      if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("m_data", a_m_data, e.d);
        check("group_idx", a_group_idx, e.g);
        check("frame_done", a_frame_done, e.l);
      end
    end
    if (hold_q && a_m_valid && rst) check("stable", a_m_data, hold_d);
    hold_q = a_m_valid && !m_ready;
    hold_d = a_m_data;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   idx, mb, mg;
    logic rdy, lst;
    logic [255:0] din, bv;

    rst = 1'b0; cfg_clear = 1'b0; cfg_ct = 8'd1; cfg_bpg = 20'd1; cfg_sat_en = 1'b1;
    bias_wr_en = 1'b0; bias_wr_addr = '0; bias_wr_data = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b1; rnd_on = 1'b0;
    #12;
    check("rst_m_valid", a_m_valid, 0);
    check("rst_m_data", a_m_data, 0);
    check("rst_frame_done", a_frame_done, 0);
    check("rst_group_idx", a_group_idx, 0);
    check("rst_fifo_count", a_fifo_count, 0);
    check("rst_s_ready", a_s_ready, 1);
    step();
    rst = 1'b1;
    step();

    // single beat, bias 1..8, latency and sign-extended copy
    set_cfg(1, 1, 1'b1);
    bias_load(0, v32(1, 1));
    push(v32(100, 0), mk(pk16(101, 1), 0, 1'b1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("latency_early", a_m_valid, 0);
    end
    @(negedge clk);
    check("latency_a", a_m_valid, 1);
    check("latency_b", b_m_valid, 1);
    check("b_data_101", b_m_data, pk48(101, 1));
    check("b_done_101", b_frame_done, 1);
    drain();

    // two groups of three beats, then wrap to group 0
    set_cfg(2, 3, 1'b1);
    bias_load(0, v32(10, 0));
    bias_load(1, v32(-5, 0));
    for (int b = 0; b < 7; b++)
      push(v32(0, 0), mk(pk16((b >= 3 && b < 6) ? -5 : 10, 0), (b >= 3 && b < 6) ? 1 : 0, b == 5));
    drain();

    // saturate vs wrap at 16 bits; the 48-bit instance sign-extends
    set_cfg(1, 1, 1'b1);
    bias_load(0, v32(5, 0));
    push(v32(32767, 0), mk(pk16(32767, 0), 0, 1'b1));
    b_expect(pk48(32772, 0));
    drain();
    bias_load(0, v32(-1, 0));
    push(v32(-32768, 0), mk(pk16(-32768, 0), 0, 1'b1));
    b_expect(pk48(-32769, 0));
    drain();
    set_cfg(1, 1, 1'b0);
    bias_load(0, v32(5, 0));
    push(v32(32767, 0), mk(pk16(-32764, 0), 0, 1'b1));
    b_expect(pk48(32772, 0));
    drain();
    bias_load(0, v32(-1, 0));
    push(v32(-32768, 0), mk(pk16(32767, 0), 0, 1'b1));
    b_expect(pk48(-32769, 0));
    drain();

    // backpressure: 4-deep FIFO plus head, S1 and output register
    set_cfg(1, 1, 1'b1);
    bias_load(0, v32(0, 0));
    m_ready = 1'b0;
    idx = 1;
    for (int c = 0; c < 12; c++) begin
      s_valid = (idx <= 8); s_data = v32(idx*100, 1);
      rdy = a_s_ready;
      step();
      if (rdy && idx <= 8) begin
        exp_q.push_back(mk(pk16(idx*100, 1), 0, 1'b1));
        idx++;
      end
    end
    check("bp_accepted", idx - 1, 6);
    check("bp_fifo_count", a_fifo_count, 4);
    check("bp_s_ready", a_s_ready, 0);
    m_ready = 1'b1;
    for (int c = 0; c < 40 && idx <= 8; c++) begin
      s_valid = 1'b1; s_data = v32(idx*100, 1);
      rdy = a_s_ready;
      step();
      if (rdy) begin
        exp_q.push_back(mk(pk16(idx*100, 1), 0, 1'b1));
        idx++;
      end
    end
    s_valid = 1'b0;
    check("bp_all_accepted", idx - 1, 8);
    drain();

    // randomised valid/ready traffic against the saturating model
    set_cfg(3, 5, 1'b1);
    for (int g = 0; g < 3; g++) begin
      for (int j = 0; j < 8; j++) begin
        bias_tb[g][j] = (g + 1) * 700 * ((j % 2 == 1) ? -1 : 1) + j;
        bv[j*32 +: 32] = 32'(bias_tb[g][j]);
      end
      bias_load(g, bv);
    end
    mb = 0; mg = 0;
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          m_ready = ($urandom_range(0, 3) != 0);
          step();
        end
        m_ready = 1'b1;
      end
    join_none
    for (int b = 0; b < 1000; b++) begin
      if ($urandom_range(0, 3) == 0) step();
      for (int j = 0; j < 8; j++) din[j*32 +: 32] = 32'(int'($urandom_range(0, 80000)) - 40000);
      lst = (mb == 4) && (mg == 2);
      push(din, model(din, mg, lst));
      if (mb == 4) begin mb = 0; mg = (mg == 2) ? 0 : mg + 1; end
      else mb++;
    end
    rnd_on = 1'b0;
    drain();

    // cfg_clear with three beats in flight and a concurrent push
    set_cfg(2, 2, 1'b1);
    bias_load(0, v32(7, 0));
    bias_load(1, v32(9, 0));
    m_ready = 1'b0;
    for (int b = 0; b < 3; b++) push(v32(0, 0), mk(pk16(0, 0), 0, 1'b0));
    step(); step(); step();
    s_valid = 1'b1; s_data = v32(1, 0); cfg_clear = 1'b1;
    step();
    cfg_clear = 1'b0; s_valid = 1'b0;
    check("clr_m_valid", a_m_valid, 0);
    check("clr_fifo_count", a_fifo_count, 0);
    exp_q.delete();
    m_ready = 1'b1;
    push(v32(0, 0), mk(pk16(7, 0), 0, 1'b0));
    drain();

    // asynchronous reset mid-stream
    set_cfg(2, 2, 1'b1);
    m_ready = 1'b0;
    for (int b = 0; b < 3; b++) push(v32(0, 0), mk(pk16(0, 0), 0, 1'b0));
    step(); step(); step();
    #2 rst = 1'b0;
    #1;
    check("arst_m_valid", a_m_valid, 0);
    check("arst_fifo_count", a_fifo_count, 0);
    check("arst_frame_done", a_frame_done, 0);
    exp_q.delete();
    step();
    rst = 1'b1;
    m_ready = 1'b1;
    step();
    push(v32(0, 0), mk(pk16(7, 0), 0, 1'b0));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/image_conv_bias_pipe.md
Name: image_conv_bias_pipe

Overview:
- Parametrised successor to the convolution bias stage. It sits between the convolution accumulator tree and the quantisation/activation stage.
- Buffers accumulator beats in an internal FIFO and adds a per-output-channel bias selected by a channel-group counter. Bias words live in a loadable on-chip bias RAM.
- Emits sign-extended or saturated results over a full valid/ready stream with backpressure. Supports configurable lane width, picture count, channel parallelism and FIFO depth.

Parameters:
- WIDTH_IN, 32, signed accumulator lane width.
- WIDTH_BIAS, 32, signed bias width per channel.
- WIDTH_OUT, 48, signed output lane width.
- PICTURE_NUM, 1, pictures processed in parallel.
- COMPUTE_CHANNEL_OUT_NUM, 8, output channels per beat (one channel group).
- FIFO_ADDR_BITS, 12, input FIFO depth = 2^FIFO_ADDR_BITS beats.
- BIAS_ADDR_BITS, 6, bias RAM depth = 2^BIAS_ADDR_BITS channel groups.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_clear  in  1  synchronous one-cycle flush: empties FIFO and pipeline, zeroes counters.
- cfg_channel_times  in  8  channel groups per frame (Channel_Out_Num/COMPUTE_CHANNEL_OUT_NUM); 0 treated as 1.
- cfg_beats_per_group  in  20  beats per channel group (pixels of the feature map); 0 treated as 1.
- cfg_sat_en  in  1  1 = saturate to WIDTH_OUT, 0 = wrap (two's-complement truncate).
- bias_wr_en  in  1  bias RAM write strobe.
- bias_wr_addr  in  BIAS_ADDR_BITS  channel-group address.
- bias_wr_data  in  COMPUTE_CHANNEL_OUT_NUM*WIDTH_BIAS  one bias per channel j at slice j.
- s_data  in  WIDTH_IN*PICTURE_NUM*COMPUTE_CHANNEL_OUT_NUM  lane k = j*PICTURE_NUM+i.
- s_valid  in  1  input beat valid.
- s_ready  out  1  equals !fifo_full.
- m_data  out  WIDTH_OUT*PICTURE_NUM*COMPUTE_CHANNEL_OUT_NUM  same lane ordering as s_data.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- fifo_count  out  FIFO_ADDR_BITS+1  FIFO occupancy.
- group_idx  out  8  group index of the beat currently in the output register.
- frame_done  out  1  high with the last beat of the last group.

Behaviour:
- Reset values (rst low): m_valid=0, m_data=0, frame_done=0, group_idx=0, fifo_count=0, s_ready=1. All counters are 0. Bias RAM contents are not reset.
- Input handshake: a beat transfers when s_valid&&s_ready. FIFO is first-word-fall-through.
  - When full, s_ready=0 and s_valid is ignored.
  - A simultaneous push and pop keeps the count unchanged.
- Pipeline has three stages: FIFO pop → S1 (data register + registered bias RAM read at group counter) → S2 (add/saturate, output register).
  - Elastic: a stage advances when it is empty or the stage after it advances. S2 advances when !m_valid||m_ready.
  - m_data/m_valid hold stable while m_valid&&!m_ready.
- Latency: with FIFO empty and m_ready=1, m_valid rises 3 cycles after the accepting edge. Steady-state throughput is 1 beat/cycle.
- Counters advance on each FIFO pop:
  - beat_cnt increments; at cfg_beats_per_group-1 it wraps to 0 and grp_cnt increments.
  - grp_cnt wraps to 0 after cfg_channel_times-1.
  - The beat popped with both counters at terminal value is tagged last. frame_done=tag in S2, qualified by m_valid.
- Arithmetic per lane k=j*PICTURE_NUM+i:
  - sum = sext(s_data lane k) + sext(bias slice j), computed at full precision max(WIDTH_IN,WIDTH_BIAS)+1.
  - If WIDTH_OUT ≥ that precision: sign-extend, no overflow possible.
  - Else, if cfg_sat_en: clamp to [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1]. Otherwise take the low WIDTH_OUT bits.
- Bias RAM write and read to the same address in the same cycle: the read returns old data.
- Group index ≥ 2^BIAS_ADDR_BITS: address uses the low BIAS_ADDR_BITS bits.
- cfg_clear:
  - Next cycle, FIFO is empty, S1/S2 are invalid, m_valid=0, counters are 0.
  - A push in the same cycle as cfg_clear is dropped.
  - Priority: rst > cfg_clear > normal operation.
- Config inputs must be static while data is in flight. Changing them mid-frame is only legal with a cfg_clear.
- Async reset assertion mid-frame drops all in-flight data immediately. Deassertion is synchronised by the top level.

Test Plan:
- Load bias addr0={1..8}. Push one beat, all lanes=100, m_ready=1 → m_valid at accept+3, lane j = 100+(j+1), frame_done=1 (config 1 group × 1 beat).
- cfg_channel_times=2, cfg_beats_per_group=3, bias addr0 all 10, addr1 all -5. Push 6 beats of 0 → outputs 10,10,10,-5,-5,-5. group_idx 0,0,0,1,1,1. frame_done only on beat 6; a 7th beat uses bias 10 again.
- Override WIDTH_OUT=16, cfg_sat_en=1: lane 32767 + bias 5 → 32767; -32768 + -1 → -32768. cfg_sat_en=0: same inputs → -32764 and 32767.
- FIFO_ADDR_BITS=2, m_ready=0, push 8 beats → s_ready drops after 4+pipeline stages filled. fifo_count=4; m_data stable. Release m_ready → all accepted beats out in order, none lost or duplicated.
- Random s_valid/m_ready toggling over 1000 beats → output sequence equals reference model. m_data never changes while m_valid&&!m_ready.
- Pulse cfg_clear with 3 beats in flight, and separately assert rst mid-stream → next cycle m_valid=0, fifo_count=0. The next pushed beat uses group 0 bias.
